scratchpad_backdoor_arb: RTL

Arbitrates and sequences 64-bit backdoor accesses to the scratchpad (main) memory port among several testbench requesters (system driver plus per-CPU drivers). Guarantees that only one requester drives the scratchpad write/mask/address/data signals at a time. Holds off while functional traffic owns the memory and returns read data or write completion to the owning requester. Sits in the co-sim DVT layer between the drivers and the scratchpad wrapper.

---
 rtl/cep_backdoor_pkg.sv | 24 ++
 rtl/bd_rr_arbiter.sv | 43 ++++
 rtl/scratchpad_backdoor_arb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cep_backdoor_pkg.sv
// Shared types and constants for the scratchpad backdoor arbiter.
package cep_backdoor_pkg;

  localparam int unsigned BD_BUSY_TO_DEF = 1024;
  localparam int unsigned BD_OWNER_W     = 3;

  typedef enum logic [1:0] {
    BD_IDLE    = 2'd0,
    BD_ISSUE   = 2'd1,
    BD_WAIT_RD = 2'd2,
    BD_RESP    = 2'd3
  } bd_state_e;

  typedef struct packed {
    logic                  we;
    logic [BD_OWNER_W-1:0] owner;
  } bd_req_rec_t;

  typedef struct packed {
    logic                  valid;
    logic [BD_OWNER_W-1:0] owner;
  } bd_rsp_beat_t;

endpackage

// File: rtl/bd_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner, pointer holds the last winner.
module bd_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               upd_i,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   gnt_idx_c,
  output logic               any_c
);

  logic [IDX_W-1:0] ptr_q, ptr_d, idx;

  // Search starts one past the last winner and wraps.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    any_c     = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!any_c && req_i[idx]) begin
        any_c      = 1'b1;
        gnt_c[idx] = 1'b1;
        gnt_idx_c  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i && any_c) ptr_d = gnt_idx_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= IDX_W'(NUM_REQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/scratchpad_backdoor_arb.sv
// Serialises full-width backdoor accesses from several requesters onto the
// scratchpad port, deferring to functional traffic while the memory is busy.
module scratchpad_backdoor_arb
  import cep_backdoor_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned BUSY_TO = BD_BUSY_TO_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  input  logic                      mem_busy_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_W/8-1:0]       mem_mask_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      bd_active_o,
  output logic                      err_timeout_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned LAT_W  = $clog2(RD_LAT + 1);
  localparam int unsigned TO_W   = $clog2(BUSY_TO + 1);
  localparam int unsigned MASK_W = DATA_W / 8;

  bd_state_e          state_q, state_d;
  bd_req_rec_t        rec_q, rec_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, addr_sel;
  logic [DATA_W-1:0]  wdata_q, wdata_d, wdata_sel;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               err_q, err_d;
  logic               we_sel;

  logic [NUM_REQ-1:0] gnt_c;
  logic [IDX_W-1:0]   gnt_idx_c;
  logic               any_req_c, grant_c, wait_busy_c;
  bd_rsp_beat_t       rsp_beat_c;

  // Grants are suppressed while reset is asserted so nothing is accepted and then lost.
  assign grant_c     = rst_n && (state_q == BD_IDLE) && any_req_c && !mem_busy_i;
  assign wait_busy_c = (state_q == BD_IDLE) && (|req_valid) && mem_busy_i;

  bd_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .upd_i     (grant_c),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .any_c     (any_req_c)
  );

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
        wdata_sel = req_wdata[i*DATA_W +: DATA_W];
        we_sel    = req_we[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BD_IDLE;
      rec_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      lat_q    <= '0;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rec_q    <= rec_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      lat_q    <= lat_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rec_d    = rec_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    lat_d    = lat_q;
    to_cnt_d = '0;
    err_d    = err_q;
    unique case (state_q)
      BD_IDLE: begin
        if (grant_c) begin
          rec_d.we    = we_sel;
          rec_d.owner = BD_OWNER_W'(gnt_idx_c);
          addr_d      = {addr_sel[ADDR_W-1:3], 3'b000};
          wdata_d     = wdata_sel;
          state_d     = BD_ISSUE;
        end
      end
      BD_ISSUE: begin
        lat_d   = LAT_W'(1);
        state_d = rec_q.we ? BD_RESP : BD_WAIT_RD;
      end
      BD_WAIT_RD: begin
        // lat_q counts cycles since the strobe; data is valid when it equals RD_LAT.
        if (lat_q == LAT_W'(RD_LAT)) begin
          rdata_d = mem_rdata_i;
          state_d = BD_RESP;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      BD_RESP:  state_d = BD_IDLE;
      default:  state_d = BD_IDLE;
    endcase
    // Starvation counter saturates; the flag is sticky until reset.
    if (wait_busy_c) begin
      to_cnt_d = (to_cnt_q == TO_W'(BUSY_TO)) ? to_cnt_q : to_cnt_q + TO_W'(1);
      if (to_cnt_q >= TO_W'(BUSY_TO - 1)) err_d = 1'b1;
    end
  end

  always_comb begin
    req_ready        = grant_c ? gnt_c : '0;
    rsp_beat_c.valid = (state_q == BD_RESP);
    rsp_beat_c.owner = rec_q.owner;
    rsp_valid        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = rsp_beat_c.valid && (rsp_beat_c.owner == BD_OWNER_W'(i));
    end
    mem_req_o     = (state_q == BD_ISSUE);
    mem_we_o      = mem_req_o && rec_q.we;
    mem_mask_o    = {MASK_W{mem_req_o}};
    mem_addr_o    = mem_req_o ? addr_q : '0;
    mem_wdata_o   = mem_req_o ? wdata_q : '0;
    bd_active_o   = (state_q != BD_IDLE);
    rsp_rdata     = rdata_q;
    err_timeout_o = err_q;
  end

endmodule
